// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg
// Purpose : shared definitions for the dual-slope ADC sequencer. Holds the
//           FSM state encoding, the err_o result codes, the default timing
//           constants and a small helper for sizing the phase counter.
// Ports   : none (package).
package adc_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AZ    = 3'd1,
    ST_INT   = 3'd2,
    ST_DEINT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'b00,
    ERR_OVR = 2'b01,
    ERR_REF = 2'b10,
    ERR_TMO = 2'b11
  } err_e;

  localparam int T_AZ_DEF        = 64;
  localparam int T_INT_DEF       = 1024;
  localparam int T_DEINT_MAX_DEF = 4095;
  localparam int CNT_W_DEF       = 12;

  localparam logic [2:0] RANGE_MAX = 3'd7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/adc_sequencer_sync.sv
// sync2
// Purpose : W-bit two-flop synchronizer for asynchronous status inputs.
//           Each bit is synchronized independently; no bus coherency is implied.
// Ports   : clk_i  - destination clock
//           rst_i  - synchronous active-high reset, clears both stages
//           d_i    - asynchronous inputs [W-1:0]
//           q_o    - synchronized outputs [W-1:0], two clk_i cycles of latency
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/adc_sequencer.sv
// adc_sequencer
// Purpose : dual-slope ADC conversion sequencer. Runs auto-zero, a fixed
//           integrate phase and a timed de-integrate phase, with optional
//           range step-up on integrator saturation.
// Ports   : clk_i, rst_i                 - clock, synchronous active-high reset
//           start_i, abort_i             - conversion request / cancel pulses
//           cfg_afe_sel_i, cfg_range_i   - channel and starting range
//           cfg_autorange_i              - allow range step-up on overrange
//           comp_i, sat_hi_i, sat_lo_i,
//           ref_ok_i                     - asynchronous AFE status inputs
//           afe_sel_o, range_sel_o,
//           afe_reset_o, ref_sign_o      - AFE controls
//           busy_o                       - conversion in progress
//           result_o, result_sign_o,
//           result_range_o, err_o        - last conversion result (held)
//           result_valid_o               - one-cycle result strobe
module adc_sequencer
  import adc_seq_pkg::*;
#(
  parameter int T_AZ        = T_AZ_DEF,
  parameter int T_INT       = T_INT_DEF,
  parameter int T_DEINT_MAX = T_DEINT_MAX_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       cfg_afe_sel_i,
  input  logic [2:0]       cfg_range_i,
  input  logic             cfg_autorange_i,
  input  logic             comp_i,
  input  logic             sat_hi_i,
  input  logic             sat_lo_i,
  input  logic             ref_ok_i,
  output logic [1:0]       afe_sel_o,
  output logic [2:0]       range_sel_o,
  output logic             afe_reset_o,
  output logic             ref_sign_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] result_o,
  output logic             result_sign_o,
  output logic [2:0]       result_range_o,
  output logic [1:0]       err_o,
  output logic             result_valid_o
);

  // Wide enough for the longest phase so the counter can never wrap.
  localparam int CW = $clog2(max3(T_AZ, T_INT, T_DEINT_MAX) + 1);

  logic [3:0] sync_s;
  logic       comp_s, sat_s, ref_ok_s;

  sync2 #(.W(4)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   ({comp_i, sat_hi_i, sat_lo_i, ref_ok_i}),
    .q_o   (sync_s)
  );

  assign comp_s   = sync_s[3];
  assign sat_s    = sync_s[2] | sync_s[1];
  assign ref_ok_s = sync_s[0];

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       afe_sel_q, afe_sel_d;
  logic [2:0]       range_sel_q, range_sel_d;
  logic             ovr_q, ovr_d;
  logic             ref_sign_q, ref_sign_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             result_sign_q, result_sign_d;
  logic [2:0]       result_range_q, result_range_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             afe_reset_q, afe_reset_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    afe_sel_d      = afe_sel_q;
    range_sel_d    = range_sel_q;
    ovr_d          = ovr_q;
    ref_sign_d     = ref_sign_q;
    result_d       = result_q;
    result_sign_d  = result_sign_q;
    result_range_d = result_range_q;
    err_d          = err_q;

    if (abort_i && (state_q != ST_IDLE)) begin
      // Cancelled conversions leave the previous result untouched.
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          ovr_d = 1'b0;
          if (start_i && !abort_i) begin
            if (!ref_ok_s) begin
              state_d        = ST_DONE;
              result_d       = '0;
              result_range_d = range_sel_q;
              err_d          = ERR_REF;
            end else begin
              afe_sel_d   = cfg_afe_sel_i;
              range_sel_d = cfg_range_i;
              state_d     = ST_AZ;
            end
          end
        end
        ST_AZ: begin
          if (cnt_q == CW'(T_AZ - 1)) begin
            cnt_d   = '0;
            state_d = ST_INT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_INT: begin
          if (sat_s) begin
            ovr_d = 1'b1;
          end
          if (cnt_q == CW'(T_INT - 1)) begin
            cnt_d         = '0;
            ref_sign_d    = comp_s;
            result_sign_d = comp_s;
            // Saturation in the final cycle counts as well.
            if (ovr_q || sat_s) begin
              if (cfg_autorange_i && (range_sel_q != RANGE_MAX)) begin
                range_sel_d = range_sel_q + 3'd1;
                ovr_d       = 1'b0;
                state_d     = ST_AZ;
              end else begin
                state_d        = ST_DONE;
                result_d       = '0;
                result_range_d = range_sel_q;
                err_d          = ERR_OVR;
              end
            end else begin
              state_d = ST_DEINT;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DEINT: begin
          // A crossing seen in the same cycle the limit is hit still counts.
          if (comp_s != ref_sign_q) begin
            state_d        = ST_DONE;
            result_d       = CNT_W'(cnt_q);
            result_range_d = range_sel_q;
            err_d          = ERR_OK;
          end else if (cnt_q == CW'(T_DEINT_MAX)) begin
            state_d        = ST_DONE;
            result_d       = CNT_W'(T_DEINT_MAX);
            result_range_d = range_sel_q;
            err_d          = ERR_TMO;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Registered decodes of the next state keep these AFE-facing lines glitch free.
    busy_d      = (state_d == ST_AZ) || (state_d == ST_INT) || (state_d == ST_DEINT);
    afe_reset_d = (state_d == ST_IDLE) || (state_d == ST_AZ) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      afe_sel_q      <= '0;
      range_sel_q    <= '0;
      ovr_q          <= 1'b0;
      ref_sign_q     <= 1'b0;
      result_q       <= '0;
      result_sign_q  <= 1'b0;
      result_range_q <= '0;
      err_q          <= ERR_OK;
      busy_q         <= 1'b0;
      afe_reset_q    <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      afe_sel_q      <= afe_sel_d;
      range_sel_q    <= range_sel_d;
      ovr_q          <= ovr_d;
      ref_sign_q     <= ref_sign_d;
      result_q       <= result_d;
      result_sign_q  <= result_sign_d;
      result_range_q <= result_range_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
      afe_reset_q    <= afe_reset_d;
    end
  end

  assign afe_sel_o      = afe_sel_q;
  assign range_sel_o    = range_sel_q;
  assign afe_reset_o    = afe_reset_q;
  assign ref_sign_o     = ref_sign_q;
  assign busy_o         = busy_q;
  assign result_o       = result_q;
  assign result_sign_o  = result_sign_q;
  assign result_range_o = result_range_q;
  assign err_o          = err_q;
  assign result_valid_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_adc_sequencer.sv
// tb_adc_sequencer
// Purpose : self-checking bench for adc_sequencer with short timing
//           parameters. Expected behaviour comes from a phase-timeline model
//           derived from the phase durations and synchronizer latency.
// Ports   : none (top-level bench).
module tb_adc_sequencer;

  localparam int TAZ  = 4;
  localparam int TINT = 16;
  localparam int TMAX = 31;
  localparam int PASS = TAZ + TINT;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, abort_i;
  logic [1:0]  cfg_afe_sel_i;
  logic [2:0]  cfg_range_i;
  logic        cfg_autorange_i;
  logic        comp_i, sat_hi_i, sat_lo_i, ref_ok_i;
  logic [1:0]  afe_sel_o;
  logic [2:0]  range_sel_o;
  logic        afe_reset_o, ref_sign_o, busy_o;
  logic [11:0] result_o;
  logic        result_sign_o;
  logic [2:0]  result_range_o;
  logic [1:0]  err_o;
  logic        result_valid_o;

  adc_sequencer #(.T_AZ(TAZ), .T_INT(TINT), .T_DEINT_MAX(TMAX), .CNT_W(12)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_afe_sel_i(cfg_afe_sel_i), .cfg_range_i(cfg_range_i),
    .cfg_autorange_i(cfg_autorange_i), .comp_i(comp_i), .sat_hi_i(sat_hi_i),
    .sat_lo_i(sat_lo_i), .ref_ok_i(ref_ok_i), .afe_sel_o(afe_sel_o),
    .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o), .ref_sign_o(ref_sign_o),
    .busy_o(busy_o), .result_o(result_o), .result_sign_o(result_sign_o),
    .result_range_o(result_range_o), .err_o(err_o), .result_valid_o(result_valid_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;

  // Model of the held/visible output registers.
  int m_sel = 0, m_range = 0, m_res = 0, m_sign = 0, m_ref = 0, m_rrange = 0, m_err = 0;
  bit m_res_known = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_held();
    check("afe_sel", 32'(afe_sel_o), m_sel);
    check("range_sel", 32'(range_sel_o), m_range);
    check("ref_sign", 32'(ref_sign_o), m_ref);
    check("res_sign", 32'(result_sign_o), m_sign);
    check("res_range", 32'(result_range_o), m_rrange);
    check("err", 32'(err_o), m_err);
    if (m_res_known) check("result", 32'(result_o), m_res);
  endtask

  // One conversion. Cycle t=0 is the first cycle after the start edge.
  // d: DEINT cycle in which raw comp flips (-1 = never).
  // abort_cyc / rst_cyc / glitch_cyc: cycle in which that pulse is driven (-1 = none).
  task automatic run_conv(input int rng, input int sel, input bit ar, input bit sgn,
                          input int sat_kind, input int sat_j, input int d,
                          input int abort_cyc, input int rst_cyc, input int glitch_cyc);
    int  passes, deint0, done_t, stop_t, last_t, e_res, e_err, ph;
    bit  final_ovr, stopped, by_rst;
    passes    = (sat_kind != 0 && ar && rng < 7) ? 2 : 1;
    final_ovr = (sat_kind != 0) && (passes == 1);
    deint0    = passes * PASS;
    if (final_ovr) begin
      done_t = deint0; e_res = 0; e_err = 1;
    end else if (d >= 0 && d + 2 <= TMAX - 1) begin
      done_t = deint0 + d + 3; e_res = d + 2; e_err = 0;  // 2-cycle sync latency
    end else begin
      done_t = deint0 + TMAX + 1; e_res = TMAX; e_err = 3;
    end
    by_rst = (rst_cyc >= 0);
    stop_t = (abort_cyc >= 0) ? abort_cyc + 1 : (by_rst ? rst_cyc + 1 : -1);
    last_t = ((stop_t >= 0) ? stop_t : done_t) + 3;

    comp_i = sgn; cfg_afe_sel_i = 2'(sel); cfg_range_i = 3'(rng);
    cfg_autorange_i = ar; start_i = 1'b1;
    step();
    start_i = 1'b0;
    m_sel = sel; m_range = rng;

    for (int t = 0; t <= last_t; t++) begin
      stopped = (stop_t >= 0) && (t >= stop_t);
      if (!stopped && t == PASS) begin
        m_sign = sgn; m_ref = sgn;
        if (passes == 2) m_range = rng + 1;
      end
      if (stopped && by_rst && t == stop_t) begin
        m_sel = 0; m_range = 0; m_res = 0; m_sign = 0; m_ref = 0;
        m_rrange = 0; m_err = 0; m_res_known = 1'b1;
      end
      if (stopped) ph = 0;
      else if (t < deint0) ph = ((t % PASS) < TAZ) ? 1 : 2;
      else if (t < done_t) ph = 3;
      else if (t == done_t) ph = 4;
      else ph = 0;
      if (ph == 4) begin
        m_res = e_res; m_err = e_err; m_rrange = m_range; m_res_known = 1'b1;
      end

      check("busy", 32'(busy_o), (ph >= 1 && ph <= 3) ? 1 : 0);
      check("valid", 32'(result_valid_o), (ph == 4) ? 1 : 0);
      if (ph <= 2) check("afe_reset", 32'(afe_reset_o), (ph == 2) ? 0 : 1);
      check_held();
      if (ph == 4)
        $display("[TB] conv rng=%0d ar=%0d sgn=%0d sat=%0d d=%0d -> result=%0d err=%0d range=%0d",
                 rng, ar, sgn, sat_kind, d, result_o, err_o, result_range_o);
      if (stopped && t == stop_t)
        $display("[TB] conv rng=%0d %s at cycle %0d -> idle busy=%0d afe_reset=%0d",
                 rng, by_rst ? "reset" : "abort", t, busy_o, afe_reset_o);

      sat_hi_i = (sat_kind == 1) && (t == TAZ + sat_j);
      sat_lo_i = (sat_kind == 2) && (t == TAZ + sat_j);
      if (!final_ovr && d >= 0 && t == deint0 + d) comp_i = ~sgn;
      start_i = (t == glitch_cyc);
      abort_i = (t == abort_cyc);
      rst_i   = (t == rst_cyc);
      step();
    end
    start_i = 1'b0; abort_i = 1'b0; rst_i = 1'b0; sat_hi_i = 1'b0; sat_lo_i = 1'b0;
  endtask

  initial begin
    int rng, sel, sgn, sk, sj, d;
    bit ar;
    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_afe_sel_i = 2'd0;
    cfg_range_i = 3'd0; cfg_autorange_i = 1'b0; comp_i = 1'b0;
    sat_hi_i = 1'b0; sat_lo_i = 1'b0; ref_ok_i = 1'b1;
    step(); step();

    // Reset state
    check("rst_afe_reset", 32'(afe_reset_o), 1);
    check("rst_busy", 32'(busy_o), 0);
    check("rst_valid", 32'(result_valid_o), 0);
    check_held();
    $display("[TB] reset: afe_reset=%0d busy=%0d err=%0d", afe_reset_o, busy_o, err_o);
    rst_i = 1'b0;
    step(); step(); step();

    // Normal conversion: raw comp falls in DEINT cycle 10 -> count 12
    run_conv(2, 1, 1'b0, 1'b1, 0, 0, 10, -1, -1, -1);
    // Autorange from 6 to 7
    run_conv(6, 2, 1'b1, 1'b0, 1, 5, 7, -1, -1, -1);
    // Overrange at the top range
    run_conv(7, 3, 1'b1, 1'b1, 2, 8, 4, -1, -1, -1);

    // Reference failure
    ref_ok_i = 1'b0;
    step(); step(); step();
    start_i = 1'b1; cfg_range_i = 3'd5; cfg_afe_sel_i = 2'd2;
    step();
    start_i = 1'b0;
    m_err = 2; m_rrange = m_range; m_res_known = 1'b0;
    check("ref_valid", 32'(result_valid_o), 1);
    check("ref_busy", 32'(busy_o), 0);
    check_held();
    $display("[TB] ref fail -> valid=%0d err=%0d range_sel=%0d", result_valid_o, err_o, range_sel_o);
    step();
    check("ref_valid_end", 32'(result_valid_o), 0);
    check("ref_afe_reset", 32'(afe_reset_o), 1);
    ref_ok_i = 1'b1;
    step(); step(); step();

    // Timeout
    run_conv(3, 0, 1'b0, 1'b1, 0, 0, -1, -1, -1, -1);
    // Abort in DEINT cycle 5 with a start pulse in INT cycle 3
    run_conv(4, 1, 1'b0, 1'b1, 0, 0, 10, PASS + 5, -1, TAZ + 3);
    // Same with reset instead of abort
    run_conv(4, 1, 1'b0, 1'b1, 0, 0, 10, -1, PASS + 5, TAZ + 3);
    step(); step(); step();

    // Abort together with start in IDLE: no conversion
    abort_i = 1'b1; start_i = 1'b1;
    step();
    abort_i = 1'b0; start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("abst_busy", 32'(busy_o), 0);
      check("abst_valid", 32'(result_valid_o), 0);
      check("abst_afe_reset", 32'(afe_reset_o), 1);
      step();
    end
    $display("[TB] abort+start in idle -> busy=%0d", busy_o);

    // Randomized conversions
    for (int n = 0; n < 12; n++) begin
      rng = $urandom_range(0, 7);
      sel = $urandom_range(0, 3);
      ar  = 1'($urandom_range(0, 1));
      sgn = $urandom_range(0, 1);
      sk  = $urandom_range(0, 2);
      sj  = $urandom_range(0, TINT - 3);
      d   = $urandom_range(0, 34);
      if (d == TMAX - 2) d = TMAX - 3;  // keep crossing off the timeout cycle
      run_conv(rng, sel, ar, 1'(sgn), sk, sj, d, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
